rv32i_decode_exec: RTL and testbench

// - Holds the current RV32I instruction and decodes it into control signals, an immediate and an ALU result.
// - Merges the control decoder, immediate extender and ALU behind one instruction register.
// - Sits between instruction fetch and the register file, PC selector and write-back mux.
// - Decode and ALU paths are combinational from the held instruction and operands.

---
 rtl/rv32i_decode_exec.sv | 203 ++++++++++++++++++++
 tb/tb_rv32i_decode_exec.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rv32i_decode_exec.sv
// rtl/rv32i_decode_exec.sv - RV32I instruction register with control decode, immediate extend and ALU
// Everything downstream of the instruction register is combinational.
module rv32i_decode_exec #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_we,
    input  logic [31:0] instr_in,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] instr,
    output logic [31:0] imm_ext,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic [31:0] alu_result,
    output logic [1:0]  pc_src,
    output logic [2:0]  result_src,
    output logic [2:0]  instruction_type,
    output logic        illegal
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    localparam logic [2:0] TYPE_R   = 3'd0;
    localparam logic [2:0] TYPE_I   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_B   = 3'd3;
    localparam logic [2:0] TYPE_U   = 3'd4;
    localparam logic [2:0] TYPE_J   = 3'd5;
    localparam logic [2:0] TYPE_UNK = 3'd7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= RESET_INSTR;
        end else if (instr_we) begin
            instr <= instr_in;
        end
    end

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

    // funct3 maps onto the same operation for OP and OP-IMM; only the SUB/SRA split differs
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt, input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm_ext          = 32'd0;
        alu_control      = ALU_ADD;
        alu_src          = 1'b0;
        pc_src           = 2'd0;
        result_src       = 3'd0;
        instruction_type = TYPE_UNK;
        illegal          = 1'b0;
        case (opcode)
            OPC_OP: begin
                instruction_type = TYPE_R;
                alu_control      = arith_op(funct3, funct7_b5, 1'b1);
            end
            OPC_OPIMM: begin
                instruction_type = TYPE_I;
                imm_ext          = imm_i;
                alu_src          = 1'b1;
                alu_control      = arith_op(funct3, funct7_b5, 1'b0);
            end
            OPC_LOAD: begin
                instruction_type = TYPE_I;
                imm_ext          = imm_i;
                alu_src          = 1'b1;
                result_src       = 3'd4;
            end
            OPC_STORE: begin
                instruction_type = TYPE_S;
                imm_ext          = imm_s;
                alu_src          = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else begin
                    instruction_type = TYPE_B;
                    imm_ext          = imm_b;
                    pc_src           = 2'd3;
                    case (funct3)
                        3'b000:  alu_control = ALU_EQ;
                        3'b001:  alu_control = ALU_NE;
                        3'b100:  alu_control = ALU_SLT;
                        3'b101:  alu_control = ALU_GE;
                        3'b110:  alu_control = ALU_SLTU;
                        default: alu_control = ALU_GEU;
                    endcase
                end
            end
            OPC_JAL: begin
                instruction_type = TYPE_J;
                imm_ext          = imm_j;
                pc_src           = 2'd1;
                result_src       = 3'd3;
            end
            OPC_JALR: begin
                instruction_type = TYPE_I;
                imm_ext          = imm_i;
                alu_src          = 1'b1;
                pc_src           = 2'd2;
                result_src       = 3'd3;
            end
            OPC_LUI: begin
                instruction_type = TYPE_U;
                imm_ext          = imm_u;
                result_src       = 3'd1;
            end
            OPC_AUIPC: begin
                instruction_type = TYPE_U;
                imm_ext          = imm_u;
                result_src       = 3'd2;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    logic [31:0] alu_b;
    logic [4:0]  shamt;

    assign alu_b = alu_src ? imm_ext : rs2;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            ALU_ADD:  alu_result = rs1 + alu_b;
            ALU_SUB:  alu_result = rs1 - alu_b;
            ALU_SLL:  alu_result = rs1 << shamt;
            ALU_SLT:  alu_result = {31'd0, $signed(rs1) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'd0, rs1 < alu_b};
            ALU_XOR:  alu_result = rs1 ^ alu_b;
            ALU_SRL:  alu_result = rs1 >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(rs1) >>> shamt);
            ALU_OR:   alu_result = rs1 | alu_b;
            ALU_AND:  alu_result = rs1 & alu_b;
            ALU_EQ:   alu_result = {31'd0, rs1 == alu_b};
            ALU_NE:   alu_result = {31'd0, rs1 != alu_b};
            ALU_GE:   alu_result = {31'd0, $signed(rs1) >= $signed(alu_b)};
            ALU_GEU:  alu_result = {31'd0, rs1 >= alu_b};
            default:  alu_result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// tb/tb_rv32i_decode_exec.sv - directed self-checking bench for rv32i_decode_exec
module tb_rv32i_decode_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_we = 1'b0;
    logic [31:0] instr_in = 32'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [31:0] instr;
    logic [31:0] imm_ext;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [31:0] alu_result;
    logic [1:0]  pc_src;
    logic [2:0]  result_src;
    logic [2:0]  instruction_type;
    logic        illegal;

    int tests = 0;
    int failed = 0;

    rv32i_decode_exec dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_we(instr_we),
        .instr_in(instr_in),
        .rs1(rs1),
        .rs2(rs2),
        .instr(instr),
        .imm_ext(imm_ext),
        .alu_control(alu_control),
        .alu_src(alu_src),
        .alu_result(alu_result),
        .pc_src(pc_src),
        .result_src(result_src),
        .instruction_type(instruction_type),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic load(input logic [31:0] word);
        @(negedge clk);
        instr_in = word;
        instr_we = 1'b1;
        @(posedge clk);
        #1;
        instr_we = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rs1 = 32'h0000_0042;
        #1;
        check("reset_instr", instr, 32'h0000_0013);
        check("reset_alu_src", {31'd0, alu_src}, 32'd1);
        check("reset_alu_result", alu_result, 32'h0000_0042);

        load(32'h4020_8033);
        rs1 = 32'd5;
        rs2 = 32'd7;
        #1;
        check("sub_ctrl", {28'd0, alu_control}, 32'd1);
        check("sub_alu_src", {31'd0, alu_src}, 32'd0);
        check("sub_result", alu_result, 32'hFFFF_FFFE);
        check("sub_type", {29'd0, instruction_type}, 32'd0);

        // asynchronous reset in the middle of a held instruction
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_instr", instr, 32'h0000_0013);
        check("midreset_imm", imm_ext, 32'd0);
        check("midreset_ctrl", {28'd0, alu_control}, 32'd0);
        check("midreset_type", {29'd0, instruction_type}, 32'd1);
        check("midreset_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load(32'hFFF0_0093);
        rs1 = 32'd1;
        #1;
        check("addi_imm", imm_ext, 32'hFFFF_FFFF);
        check("addi_result", alu_result, 32'd0);
        instr_in = 32'h0000_007F;
        repeat (2) @(posedge clk);
        #1;
        check("addi_held", instr, 32'hFFF0_0093);

        load(32'h4040_D093);
        rs1 = 32'h8000_0000;
        #1;
        check("srai_imm", imm_ext, 32'h0000_0404);
        check("srai_ctrl", {28'd0, alu_control}, 32'd7);
        check("srai_result", alu_result, 32'hF800_0000);

        load(32'hFE20_8CE3);
        rs1 = 32'd3;
        rs2 = 32'd3;
        #1;
        check("beq_imm", imm_ext, 32'hFFFF_FFF8);
        check("beq_pc_src", {30'd0, pc_src}, 32'd3);
        check("beq_taken", alu_result, 32'd1);
        rs2 = 32'd4;
        #1;
        check("beq_not_taken", alu_result, 32'd0);

        load(32'h0020_A423);
        rs1 = 32'h0000_1000;
        #1;
        check("sw_imm", imm_ext, 32'd8);
        check("sw_type", {29'd0, instruction_type}, 32'd2);
        check("sw_addr", alu_result, 32'h0000_1008);

        load(32'h0080_00EF);
        #1;
        check("jal_imm", imm_ext, 32'd8);
        check("jal_pc_src", {30'd0, pc_src}, 32'd1);
        check("jal_result_src", {29'd0, result_src}, 32'd3);
        check("jal_type", {29'd0, instruction_type}, 32'd5);

        load(32'h0020_A063);
        #1;
        check("bfunct3_illegal", {31'd0, illegal}, 32'd1);
        check("bfunct3_type", {29'd0, instruction_type}, 32'd7);
        check("bfunct3_pc_src", {30'd0, pc_src}, 32'd0);

        load(32'h1234_52B7);
        #1;
        check("lui_imm", imm_ext, 32'h1234_5000);
        check("lui_result_src", {29'd0, result_src}, 32'd1);
        check("lui_type", {29'd0, instruction_type}, 32'd4);

        load(32'h0000_007F);
        #1;
        check("unk_illegal", {31'd0, illegal}, 32'd1);
        check("unk_type", {29'd0, instruction_type}, 32'd7);
        check("unk_imm", imm_ext, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
